if_fetch_queue: RTL

IF_FETCH_QUEUE -- requirements
Module: if_fetch_queue

---
 rtl/if_fetch_queue.sv | 118 +++++++++++
 1 files changed

// File: rtl/if_fetch_queue.sv
// Instruction fetch queue: accepts FETCH_WIDTH-wide fetch groups, compacts the
// valid slots into a circular buffer and hands one instruction per pop to decode.
module if_fetch_queue #(
  parameter int DEPTH       = 8,
  parameter int FETCH_WIDTH = 2,
  parameter int EXC_W       = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      push_valid,
  output logic                      push_ready,
  input  logic [31:0]               push_pc,
  input  logic [32*FETCH_WIDTH-1:0] push_instr,
  input  logic [FETCH_WIDTH-1:0]    push_mask,
  input  logic [EXC_W-1:0]          push_exc,
  output logic                      pop_valid,
  input  logic                      pop_ready,
  output logic [31:0]               pop_pc,
  output logic [31:0]               pop_instr,
  output logic [EXC_W-1:0]          pop_exc,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]      pc_mem_q    [DEPTH];
  logic [31:0]      instr_mem_q [DEPTH];
  logic [EXC_W-1:0] exc_mem_q   [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic                   do_push, do_pop;
  logic [CW-1:0]          n_push;
  logic [FETCH_WIDTH-1:0] wr_en;
  logic [AW-1:0]          wr_addr  [FETCH_WIDTH];
  logic [31:0]            wr_pc    [FETCH_WIDTH];
  logic [31:0]            wr_instr [FETCH_WIDTH];
  logic [EXC_W-1:0]       wr_exc   [FETCH_WIDTH];

  always_comb begin
    // Only the registered occupancy gates acceptance; a same-cycle pop earns no credit.
    push_ready = !flush && (count_q <= CW'(DEPTH - FETCH_WIDTH));
    pop_valid  = (count_q != '0);
    do_push    = push_valid && push_ready;
    do_pop     = pop_valid && pop_ready;

    n_push = '0;
    wr_en  = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      wr_addr[i]  = '0;
      wr_pc[i]    = '0;
      wr_instr[i] = '0;
      wr_exc[i]   = '0;
    end

    // A faulting group collapses to a single marker entry carrying the exception.
    if (push_exc != '0) begin
      wr_en[0]    = do_push;
      wr_addr[0]  = wr_ptr_q;
      wr_pc[0]    = push_pc;
      wr_exc[0]   = push_exc;
      n_push      = CW'(1);
    end else begin
      for (int i = 0; i < FETCH_WIDTH; i++) begin
        if (push_mask[i]) begin
          wr_en[i]    = do_push;
          wr_addr[i]  = wr_ptr_q + AW'(n_push);
          wr_pc[i]    = push_pc + 32'(4 * i);
          wr_instr[i] = push_instr[32*i +: 32];
          n_push      = n_push + CW'(1);
        end
      end
    end

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = do_push ? wr_ptr_q + AW'(n_push) : wr_ptr_q;
      rd_ptr_d = rd_ptr_q + AW'(do_pop);
      count_d  = count_q + (do_push ? n_push : '0) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage holds no reset: pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (wr_en[i]) begin
        pc_mem_q[wr_addr[i]]    <= wr_pc[i];
        instr_mem_q[wr_addr[i]] <= wr_instr[i];
        exc_mem_q[wr_addr[i]]   <= wr_exc[i];
      end
    end
  end

  assign pop_pc    = pop_valid ? pc_mem_q[rd_ptr_q]    : '0;
  assign pop_instr = pop_valid ? instr_mem_q[rd_ptr_q] : '0;
  assign pop_exc   = pop_valid ? exc_mem_q[rd_ptr_q]   : '0;
  assign count     = count_q;

endmodule
